imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the width of the memory address bus.
REQ-002 The block SHALL have parameter DEPTH_BYTES, default 1024, meaning the instruction-memory size in bytes; it SHALL be a multiple of 4.
REQ-003 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  single-cycle pulse that begins a load.
REQ-006 The block SHALL have port in_valid  input  1  in_byte holds a valid byte.
REQ-007 The block SHALL have port in_byte  input  8  byte of the load stream.
REQ-008 The block SHALL have port in_ready  output  1  block accepts in_byte this cycle.
REQ-009 The block SHALL have port mem_we  output  1  byte write strobe to instruction memory.
REQ-010 The block SHALL have port mem_addr  output  W  byte address of the write.
REQ-011 The block SHALL have port mem_wdata  output  8  byte to write.
REQ-012 The block SHALL have port cpu_hold  output  1  holds the processor in reset while high.
REQ-013 The block SHALL have port done  output  1  the load completed successfully.
REQ-014 The block SHALL have port error  output  1  the load was aborted.

Function
REQ-015 A byte SHALL be accepted on a rising clk edge with in_valid=1 and in_ready=1; in_valid with in_ready=0 SHALL be ignored.
REQ-016 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE and ERROR.
REQ-017 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA and CHK.
REQ-018 A start pulse in IDLE, DONE or ERROR SHALL go to LEN_HI, clear the word count, byte address, checksum, done and error, and set cpu_hold=1; start SHALL be ignored in other states.
REQ-019 LEN_HI SHALL accept the length-count MSB and go to LEN_LO; LEN_LO SHALL accept the LSB, forming a 16-bit word count N.
REQ-020 If N > DEPTH_BYTES/4, LEN_LO SHALL go to ERROR with no memory write.
REQ-021 If N=0, LEN_LO SHALL go to CHK when IMEM_LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-022 Otherwise LEN_LO SHALL go to DATA; DATA SHALL accept 4*N bytes written to byte addresses 0..4N-1 in arrival order, so each word is stored MSB first at the lowest address (big-endian).
REQ-023 Each accepted DATA byte SHALL produce, on the next cycle, a one-cycle mem_we=1 with mem_addr equal to the byte index, zero-extended to W, and mem_wdata equal to the byte; outside such cycles mem_we SHALL be 0.
REQ-024 Back-to-back bytes (one per cycle) SHALL be supported with no bubbles.
REQ-025 After the 4N-th byte, DATA SHALL go to CHK when IMEM_LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-026 In DONE, done SHALL be 1 and cpu_hold SHALL be 0, with the final mem_we for the last byte asserted in the same cycle DONE is entered.
REQ-027 In ERROR, error SHALL be 1 and cpu_hold SHALL remain 1.
REQ-028 done and error SHALL never be 1 together.
REQ-029 The byte counter SHALL be wide enough for 4*DEPTH_BYTES/4 and SHALL never wrap within a legal load.

Reset
REQ-030 rst=1 SHALL force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, and clear the counters and checksum, immediately and independent of clk.
REQ-031 rst asserted mid-load SHALL abort the load with no further mem_we; bytes already written SHALL remain in memory.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all length and data bytes, and CHK SHALL accept one byte: a match SHALL go to DONE and a mismatch SHALL go to ERROR.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, the CHK state and checksum logic SHALL be absent, and the stream SHALL carry no checksum byte.

Verification
REQ-034 The bench SHALL cover: reset, start, stream 00 01 00 00 00 93 (+checksum 92 if enabled) -> mem writes addr0..3 = 00,00,00,93; done=1; cpu_hold=0.
REQ-035 The bench SHALL cover: start, length 01 01 (257 > 256) -> error=1, no mem_we, in_ready=0, cpu_hold=1.
REQ-036 The bench SHALL cover: N=2 with in_valid held high for 8 consecutive cycles -> 8 consecutive mem_we pulses at addr0..7; in_valid gaps SHALL only delay writes.
REQ-037 The bench SHALL cover: rst asserted after the 3rd data byte of an N=4 load -> mem_we=0 from reset onward, state IDLE, cpu_hold=1; a restart then completes normally.
REQ-038 The bench SHALL cover, checksum enabled: N=1, data 11 22 33 44, checksum byte 00 (correct value 45) -> error=1 and done=0.
REQ-039 The bench SHALL cover: N=0 (plus checksum 00 if enabled) -> done=1 with no mem_we; a start pulse while in DATA SHALL be ignored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it into instruction memory
// while holding the processor in reset.
// Stream format: length MSB, length LSB (N words), then 4*N data bytes. Words are big-endian.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte. The checksum
// covers the two length bytes and all data bytes.
module imem_loader #(
    parameter int unsigned W           = 32,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [7:0]   mem_wdata,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    localparam int unsigned MaxWords = DEPTH_BYTES / 4;
    // Wide enough to hold the full byte count of a maximum-size load.
    localparam int unsigned CntW     = $clog2(DEPTH_BYTES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk,
`endif
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [CntW-1:0]   total_q, total_d;
    logic [CntW-1:0]   addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [W-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              accept;
    logic [15:0]       n_words;
    logic              len_ok;
    logic              last_byte;

    // Handshake and length decode helpers.
    always_comb begin
        accept    = in_valid && in_ready;
        n_words   = {len_hi_q, in_byte};
        len_ok    = ({16'd0, n_words} <= MaxWords);
        last_byte = (addr_q == (total_q - CntW'(1)));
    end

    // Next-state logic and write-port staging.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        total_d     = total_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
        // The checksum byte itself is not folded into the running XOR.
        if (accept && (state_q != StChk)) begin
            chk_d = chk_q ^ in_byte;
        end
`endif
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d  = StLenHi;
                    len_hi_d = 8'd0;
                    total_d  = '0;
                    addr_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d    = 8'd0;
`endif
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_byte;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (!len_ok) begin
                        state_d = StError;
                    end else if (n_words == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StData;
                        // Truncation is safe: n_words is already bounded by MaxWords here.
                        total_d = CntW'({n_words, 2'b00});
                    end
                end
            end
            StData: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = W'(addr_q);
                    mem_wdata_d = in_byte;
                    addr_d      = addr_q + CntW'(1);
                    if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    state_d = (in_byte == chk_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronously cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_hi_q    <= 8'd0;
            total_q     <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            total_q     <= total_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state_q == StChk)
`endif
                    ;
        done      = (state_q == StDone);
        error     = (state_q == StError);
        cpu_hold  = (state_q != StDone);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. Checksum bytes are sent only when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_ready;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [7:0]   mem_wdata;
    logic         cpu_hold;
    logic         done;
    logic         error;

    int n_checks = 0;
    int n_pass   = 0;

    imem_loader #(.W(W), .DEPTH_BYTES(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled on the falling edge.
    logic [W-1:0] log_addr [64];
    logic [7:0]   log_data [64];
    int           log_cyc  [64];
    int           wr_n = 0;
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_n < 64) begin
            log_addr[wr_n] <= mem_addr;
            log_data[wr_n] <= mem_wdata;
            log_cyc[wr_n]  <= cyc;
            wr_n           <= wr_n + 1;
        end
    end

    // All tasks start and end on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        #3;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h00) $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_done_err got %b%b want 00", done, error); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        // Bytes without a start pulse must be ignored.
        send(8'h55);
        idle(1);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (wr_n !== 0) $display("FAIL idle_no_write got %0d want 0", wr_n); else n_pass++;
    endtask

    task automatic test_basic();
        int base;
        logic [7:0] exp [4];
        exp = '{8'h00, 8'h00, 8'h00, 8'h93};
        base = wr_n;
        pulse_start();
        n_checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL start_lenhi got rdy=%b hold=%b want 1 1", in_ready, cpu_hold); else n_pass++;
        send(8'h00); send(8'h01);
        send(8'h00); send(8'h00); send(8'h00); send(8'h93);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h92);
`else
        n_checks++; if (done !== 1'b1 || mem_we !== 1'b1) $display("FAIL basic_done_with_last_we got done=%b we=%b want 1 1", done, mem_we); else n_pass++;
`endif
        idle(1);
        n_checks++; if (wr_n - base !== 4) $display("FAIL basic_wr_count got %0d want 4", wr_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_addr[base+i] !== W'(i) || log_data[base+i] !== exp[i])
                $display("FAIL basic_wr%0d got %h/%h want %h/%h", i, log_addr[base+i], log_data[base+i], i, exp[i]);
            else n_pass++;
        end
        n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL basic_done got %b%b want 10", done, error); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL basic_cpu_hold got %b want 0", cpu_hold); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready got %b want 0", in_ready); else n_pass++;
    endtask

    task automatic test_len_error();
        int base;
        base = wr_n;
        pulse_start();
        send(8'h01); send(8'h01);
        idle(1);
        n_checks++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL len_err_flags got e=%b d=%b want 1 0", error, done); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL len_err_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL len_err_cpu_hold got %b want 1", cpu_hold); else n_pass++;
        send(8'hAA);
        idle(1);
        n_checks++; if (wr_n - base !== 0) $display("FAIL len_err_no_write got %0d want 0", wr_n - base); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h02);
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h02);
`endif
        idle(1);
        n_checks++; if (wr_n - base !== 8) $display("FAIL b2b_wr_count got %0d want 8", wr_n - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_addr[base+i] !== W'(i) || log_data[base+i] !== 8'h10 + 8'(i) ||
                log_cyc[base+i] - log_cyc[base] !== i)
                $display("FAIL b2b_wr%0d got %h/%h cyc+%0d want %h/%h cyc+%0d", i, log_addr[base+i],
                         log_data[base+i], log_cyc[base+i] - log_cyc[base], i, 8'h10 + 8'(i), i);
            else n_pass++;
        end
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else n_pass++;
    endtask

    task automatic test_gaps();
        int base;
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'hA1); idle(2); send(8'hB2); idle(1); send(8'hC3); send(8'hD4);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h05);
`endif
        idle(1);
        n_checks++; if (wr_n - base !== 4) $display("FAIL gap_wr_count got %0d want 4", wr_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_addr[base+i] !== W'(i) || log_data[base+i] !== exp[i])
                $display("FAIL gap_wr%0d got %h/%h want %h/%h", i, log_addr[base+i], log_data[base+i], i, exp[i]);
            else n_pass++;
        end
        n_checks++; if (done !== 1'b1) $display("FAIL gap_done got %b want 1", done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_rst_mem_we got %b want 0", mem_we); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_rst_idle got hold=%b rdy=%b want 1 0", cpu_hold, in_ready); else n_pass++;
        @(negedge clk);
        in_valid = 1'b1; in_byte = 8'h04;
        @(negedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        idle(1);
        n_checks++; if (wr_n - base !== 3) $display("FAIL mid_rst_wr_count got %0d want 3", wr_n - base); else n_pass++;
        n_checks++; if (log_data[base+2] !== 8'h03 || log_addr[base+2] !== W'(2)) $display("FAIL mid_rst_wr2 got %h/%h want 2/03", log_addr[base+2], log_data[base+2]); else n_pass++;
        n_checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL mid_rst_flags got %b%b want 00", done, error); else n_pass++;
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h23);
`endif
        idle(1);
        n_checks++; if (wr_n - base !== 4) $display("FAIL restart_wr_count got %0d want 4", wr_n - base); else n_pass++;
        n_checks++; if (log_data[base] !== 8'hDE || log_addr[base+3] !== W'(3) || log_data[base+3] !== 8'hEF)
            $display("FAIL restart_data got %h %h/%h want DE 3/EF", log_data[base], log_addr[base+3], log_data[base+3]); else n_pass++;
        n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL restart_done got d=%b hold=%b want 1 0", done, cpu_hold); else n_pass++;
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(1);
        n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL zero_done got %b%b want 10", done, error); else n_pass++;
        n_checks++; if (wr_n - base !== 0) $display("FAIL zero_no_write got %0d want 0", wr_n - base); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int base;
        logic [7:0] exp [4];
        exp = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'h5A); send(8'h6B);
        pulse_start();
        n_checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL data_start_state got rdy=%b hold=%b want 1 1", in_ready, cpu_hold); else n_pass++;
        send(8'h7C); send(8'h8D);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hC1);
`endif
        idle(1);
        n_checks++; if (wr_n - base !== 4) $display("FAIL data_start_wr_count got %0d want 4", wr_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_addr[base+i] !== W'(i) || log_data[base+i] !== exp[i])
                $display("FAIL data_start_wr%0d got %h/%h want %h/%h", i, log_addr[base+i], log_data[base+i], i, exp[i]);
            else n_pass++;
        end
        n_checks++; if (done !== 1'b1) $display("FAIL data_start_done got %b want 1", done); else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base;
        base = wr_n;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h00);
        idle(1);
        n_checks++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL bad_chk_flags got e=%b d=%b want 1 0", error, done); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL bad_chk_cpu_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (wr_n - base !== 4) $display("FAIL bad_chk_wr_count got %0d want 4", wr_n - base); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len_error();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_zero_len();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

endmodule
